// File: rtl/rom_fetch_buffer_if.sv
// Bundle of the ROM-side request/ack bus and the core-side fetch/redirect
// signals seen by the prefetch buffer.
interface rom_fetch_buffer_if #(
  parameter int unsigned ADDR_WIDTH = 16
) ();
  logic [ADDR_WIDTH-3:0] rom_addr_o;
  logic                  rom_stb_o;
  logic [31:0]           rom_data_i;
  logic                  rom_ack_i;
  logic                  redirect_i;
  logic [ADDR_WIDTH-1:0] redirect_addr_i;
  logic [31:0]           instr_o;
  logic [ADDR_WIDTH-1:0] pc_o;
  logic                  valid_o;
  logic                  ready_i;

  modport master (
    output rom_addr_o, rom_stb_o, instr_o, pc_o, valid_o,
    input  rom_data_i, rom_ack_i, redirect_i, redirect_addr_i, ready_i
  );

  modport slave (
    input  rom_addr_o, rom_stb_o, instr_o, pc_o, valid_o,
    output rom_data_i, rom_ack_i, redirect_i, redirect_addr_i, ready_i
  );
endinterface

// File: rtl/rom_fetch_buffer.sv
// Instruction prefetch stage: sequential single-outstanding ROM reads captured
// into a small FIFO, with redirect flushing of buffered and in-flight words.
module rom_fetch_buffer #(
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter int unsigned           DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_ADDR = '0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  rom_fetch_buffer_if.master bus
);

  localparam int unsigned   WA         = ADDR_WIDTH - 2;
  localparam int unsigned   PW         = $clog2(DEPTH);
  localparam int unsigned   CW         = PW + 1;
  localparam logic [WA-1:0] RESET_WORD = RESET_ADDR[ADDR_WIDTH-1:2];
  localparam logic [CW-1:0] FULL       = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;

  state_t        state;
  logic          stb_q;
  logic [WA-1:0] addr_q;
  logic [WA-1:0] fetch_ptr;
  logic [WA-1:0] target;

  logic [31:0]   data_mem [DEPTH];
  logic [WA-1:0] pc_mem   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;

  logic          ack;
  logic          push;
  logic          pop;
  logic          credit;
  logic          redirect;
  logic          valid;
  logic [WA-1:0] redirect_word;
  logic [WA-1:0] seq_ptr;
  logic [WA-1:0] flush_word;
  logic [1:0]    unused_addr_bits;

  assign redirect         = bus.redirect_i;
  assign redirect_word    = bus.redirect_addr_i[ADDR_WIDTH-1:2];
  assign unused_addr_bits = bus.redirect_addr_i[1:0];
  assign seq_ptr          = fetch_ptr + WA'(1);
  assign flush_word       = redirect ? redirect_word : target;
  assign valid            = (count != '0);

  // Acks only complete a live request; in FLUSH the returned word is dropped.
  assign ack  = bus.rom_ack_i & stb_q;
  assign push = ack & (state == BUSY) & ~redirect;
  assign pop  = valid & bus.ready_i & ~redirect;

  always_comb begin
    count_after = count;
    if (redirect) begin
      count_after = '0;
    end else if (push && !pop) begin
      count_after = count + CW'(1);
    end else if (pop && !push) begin
      count_after = count - CW'(1);
    end
  end

  // A new request is only issued when it is guaranteed a FIFO slot.
  assign credit = (count_after < FULL);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      stb_q     <= 1'b0;
      addr_q    <= RESET_WORD;
      fetch_ptr <= RESET_WORD;
      target    <= RESET_WORD;
    end else begin
      unique case (state)
        IDLE: begin
          if (redirect) begin
            fetch_ptr <= redirect_word;
            addr_q    <= redirect_word;
            stb_q     <= 1'b1;
            state     <= BUSY;
          end else if (credit) begin
            addr_q <= fetch_ptr;
            stb_q  <= 1'b1;
            state  <= BUSY;
          end
        end
        BUSY: begin
          if (ack) begin
            if (redirect) begin
              fetch_ptr <= redirect_word;
              addr_q    <= redirect_word;
              stb_q     <= 1'b1;
            end else begin
              fetch_ptr <= seq_ptr;
              addr_q    <= seq_ptr;
              stb_q     <= credit;
              state     <= credit ? BUSY : IDLE;
            end
          end else if (redirect) begin
            target <= redirect_word;
            state  <= FLUSH;
          end
        end
        FLUSH: begin
          if (ack) begin
            fetch_ptr <= flush_word;
            addr_q    <= flush_word;
            stb_q     <= credit;
            state     <= credit ? BUSY : IDLE;
          end else if (redirect) begin
            target <= redirect_word;
          end
        end
        default: begin
          state <= IDLE;
          stb_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count_after;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      data_mem[wr_ptr] <= bus.rom_data_i;
      pc_mem[wr_ptr]   <= fetch_ptr;
    end
  end

  assign bus.rom_stb_o  = stb_q;
  assign bus.rom_addr_o = addr_q;
  assign bus.valid_o    = valid;
  assign bus.instr_o    = valid ? data_mem[rd_ptr] : '0;
  assign bus.pc_o       = valid ? {pc_mem[rd_ptr], 2'b00} : '0;

endmodule

// File: doc/rom_fetch_buffer.md
Name: rom_fetch_buffer

Overview:
- Instruction prefetch stage placed directly upstream of the single-port Wishbone ROM.
- Issues sequential word reads over the ROM's stb/ack handshake and captures the returned words into a small FIFO.
- Presents instruction and PC to the core over a valid/ready interface.
- Supports redirects (branch/jump): flushes buffered words and discards any in-flight response.

Parameters:
- ADDR_WIDTH, 16: byte-address width. Word address = ADDR_WIDTH-2 bits.
- DEPTH, 4: FIFO entries. Power of two, at least 2.
- RESET_ADDR, 0: byte address of the first fetch after reset. Bits [1:0] are ignored.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- rom_addr_o  out  ADDR_WIDTH-2  word address to ROM (addr_i[ADDR_WIDTH-1:2]).
- rom_stb_o  out  1  request strobe to ROM.
- rom_data_i  in  32  read data from ROM, valid when rom_ack_i=1.
- rom_ack_i  in  1  ROM acknowledge.
- redirect_i  in  1  one-cycle pulse: restart fetch at redirect_addr_i.
- redirect_addr_i  in  ADDR_WIDTH  new byte PC. Bits [1:0] are ignored.
- instr_o  out  32  instruction word at FIFO head.
- pc_o  out  ADDR_WIDTH  byte PC of instr_o. Bits [1:0] = 0.
- valid_o  out  1  FIFO head is valid.
- ready_i  in  1  core accepts head. A pop occurs when valid_o & ready_i.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high on rst_i, and overrides all other inputs.
- Reset values:
  - rom_stb_o=0, rom_addr_o=RESET_ADDR[ADDR_WIDTH-1:2].
  - valid_o=0, instr_o=0, pc_o=0.
  - FIFO count=0, FSM=IDLE.
- Output zeroing: instr_o and pc_o are 0 whenever valid_o=0.
- ROM protocol:
  - Classic single outstanding request. rom_addr_o and rom_stb_o are registered and held stable until a cycle with rom_ack_i=1.
  - Data is sampled only in the ack cycle.
  - The ROM acks one cycle after it samples stb and never acks twice back-to-back, so peak throughput is 1 word per 2 cycles.
- Credit rule: a new request may be issued only if (count + in-flight) < DEPTH, where count is evaluated after this cycle's push and pop. The FIFO therefore never overflows, and no ack is ever dropped for lack of space.
- FSM:
  - IDLE: stb=0.
    - Moves to BUSY when the credit rule allows, driving stb=1 and addr=fetch_ptr the next cycle.
    - The first cycle after reset goes IDLE->BUSY (DEPTH>=1 is free).
  - BUSY: stb=1, waiting for ack.
    - On ack: push {rom_data_i, fetch_ptr}; fetch_ptr += 1 (mod 2^(ADDR_WIDTH-2), wraps to 0).
    - If credit remains, stay BUSY with the new addr (back-to-back issue). Otherwise go to IDLE with stb=0.
  - FLUSH: stb=1 with the old addr held, waiting for ack.
    - On ack: discard the data, load fetch_ptr=target.
    - Go to BUSY next cycle if credit allows, otherwise IDLE.
- Redirect (redirect_i=1):
  - FIFO is emptied and valid_o=0 next cycle. A simultaneous pop is ignored.
  - A simultaneous ack is discarded, never pushed.
  - IDLE, or BUSY with ack this cycle: fetch_ptr=redirect_addr_i[ADDR_WIDTH-1:2]; next state BUSY with the new addr.
  - BUSY without ack: save the target and enter FLUSH.
  - FLUSH without ack: overwrite the saved target and remain in FLUSH. The latest redirect wins.
- FIFO:
  - Circular, with log2(DEPTH)-bit pointers and a (log2(DEPTH)+1)-bit count.
  - Simultaneous push and pop when full or empty is legal.
  - Push into an empty FIFO appears at valid_o the next cycle; there is no combinational bypass.
- Latency: the ack cycle is N, so valid_o=1 in cycle N+1. After reset deasserts (cycle 0), stb=1 in cycle 1, ack in cycle 2, valid_o in cycle 3.
- pc_o equals the stored word address concatenated with 2'b00.
- Reset mid-operation: any in-flight request is abandoned and stb=0 next cycle. The ROM's own reset clears its ack, so no stale ack reaches this block after reset.

Test Plan:
- Reset, RESET_ADDR=0x100, ROM words mem[0x40..]=0xA0,0xA1,..., ready_i=1 -> valid_o first high in cycle 3 with instr=0xA0, pc=0x100. Subsequent words arrive every 2 cycles with pc +4.
- ready_i=0 held, DEPTH=4 -> exactly 4 acks then rom_stb_o=0, count=4. Raise ready_i -> 4 words pop in order 0xA0..0xA3, fetch resumes at 0x110, and no word is lost or duplicated.
- redirect_i to 0x200 in a BUSY cycle without ack -> FLUSH. The next ack's data is not pushed. The next request has addr 0x80. The first valid_o shows pc=0x200.
- redirect_i coincident with ack and with a pop, FIFO holding 2 entries -> FIFO empty next cycle. The acked word never appears. The next request uses the new addr.
- Two redirects (0x200 then 0x300) during one FLUSH -> only the 0x300 stream is delivered.
- ADDR_WIDTH=8, redirect to 0xF8 -> pcs 0xF8, 0xFC, 0x00, 0x04 (wrap). Assert rst_i mid-BUSY -> stb=0 and valid_o=0 next cycle, then fetch restarts at RESET_ADDR.
